// File: rtl/pe_psum_accumulator.sv
// PE-local partial-sum scratchpad: saturating accumulate of multiplier
// products into DEPTH entries, drained in address order over valid/ready.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_prod_valid/o_prod_ready, i_prod, i_prod_addr, i_prod_first
//                          product input stream (first = overwrite entry)
//   o_mul_gate             high while no product can be accepted
//   i_drain_start, i_drain_len, i_drain_clear
//                          drain request for entries 0..len, optional clear
//   o_psum_out_valid/i_psum_out_ready, o_psum_out
//                          drained psum stream
//   o_drain_done           one-cycle pulse after the last drained word
//   o_ovf                  sticky saturation flag

`ifndef PSUM_SIZE
`define PSUM_SIZE 32
`endif

module pe_psum_accumulator #(
    parameter int PSUM_SIZE = `PSUM_SIZE,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_prod_valid,
    output logic                 o_prod_ready,
    input  logic [PSUM_SIZE-1:0] i_prod,
    input  logic [ADDR_W-1:0]    i_prod_addr,
    input  logic                 i_prod_first,
    output logic                 o_mul_gate,
    input  logic                 i_drain_start,
    input  logic [ADDR_W-1:0]    i_drain_len,
    input  logic                 i_drain_clear,
    output logic                 o_psum_out_valid,
    input  logic                 i_psum_out_ready,
    output logic [PSUM_SIZE-1:0] o_psum_out,
    output logic                 o_drain_done,
    output logic                 o_ovf
);

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [PSUM_SIZE-1:0] SAT_MAX = {1'b0, {(PSUM_SIZE-1){1'b1}}};
    localparam logic [PSUM_SIZE-1:0] SAT_MIN = {1'b1, {(PSUM_SIZE-1){1'b0}}};

    logic [1:0]           r_state;
    logic [PSUM_SIZE-1:0] r_mem [DEPTH];

    logic                 r_s1_valid;
    logic [PSUM_SIZE-1:0] r_s1_prod;
    logic [ADDR_W-1:0]    r_s1_addr;
    logic                 r_s1_first;

    logic [ADDR_W-1:0]    r_idx;
    logic [ADDR_W-1:0]    r_len;
    logic                 r_clr;
    logic                 r_out_valid;
    logic [PSUM_SIZE-1:0] r_out;
    logic                 r_done;
    logic                 r_ovf;

    logic                 w_acc;
    logic                 w_hs;
    logic [PSUM_SIZE-1:0] w_rd;
    logic [PSUM_SIZE:0]   w_sum;
    logic                 w_pos_sat;
    logic                 w_neg_sat;
    logic                 w_sat;
    logic [PSUM_SIZE-1:0] w_wdata;
    logic [ADDR_W-1:0]    w_nidx;
    logic [ADDR_W-1:0]    w_fetch_idx;
    logic [PSUM_SIZE-1:0] w_fetch;

    assign o_prod_ready     = (r_state == ST_ACC);
    assign o_mul_gate       = ~o_prod_ready;
    assign o_psum_out_valid = r_out_valid;
    assign o_psum_out       = r_out;
    assign o_drain_done     = r_done;
    assign o_ovf            = r_ovf;

    assign w_acc = i_prod_valid & o_prod_ready;
    assign w_hs  = r_out_valid & i_psum_out_ready;

    always_comb begin
        w_rd      = r_mem[r_s1_addr];
        // One guard bit: overflow shows as the top two sum bits differing.
        w_sum     = {w_rd[PSUM_SIZE-1], w_rd}
                  + {r_s1_prod[PSUM_SIZE-1], r_s1_prod};
        w_pos_sat = ~w_sum[PSUM_SIZE] & w_sum[PSUM_SIZE-1];
        w_neg_sat = w_sum[PSUM_SIZE] & ~w_sum[PSUM_SIZE-1];
        w_sat     = r_s1_valid & ~r_s1_first & (w_pos_sat | w_neg_sat);
        if (r_s1_first) begin
            w_wdata = r_s1_prod;
        end else if (w_pos_sat) begin
            w_wdata = SAT_MAX;
        end else if (w_neg_sat) begin
            w_wdata = SAT_MIN;
        end else begin
            w_wdata = w_sum[PSUM_SIZE-1:0];
        end
    end

    // Next drain word: entry 0 when leaving FLUSH, else idx+1. The FLUSH
    // write lands on the same edge, so forward it into the output register.
    always_comb begin
        w_nidx      = r_idx + ADDR_W'(1);
        w_fetch_idx = (r_state == ST_FLUSH) ? '0 : w_nidx;
        if (r_s1_valid && (r_s1_addr == w_fetch_idx)) begin
            w_fetch = w_wdata;
        end else begin
            w_fetch = r_mem[w_fetch_idx];
        end
    end

    // S2 writes never coincide with drain clears: S1 is empty in DRAIN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_s1_valid) begin
            r_mem[r_s1_addr] <= w_wdata;
        end else if (w_hs && r_clr) begin
            r_mem[r_idx] <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ACC;
            r_s1_valid  <= 1'b0;
            r_s1_prod   <= '0;
            r_s1_addr   <= '0;
            r_s1_first  <= 1'b0;
            r_idx       <= '0;
            r_len       <= '0;
            r_clr       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_prod  <= i_prod;
                r_s1_addr  <= i_prod_addr;
                r_s1_first <= i_prod_first;
            end
            unique case (r_state)
                ST_ACC: begin
                    if (i_drain_start) begin
                        r_len   <= i_drain_len;
                        r_clr   <= i_drain_clear;
                        r_ovf   <= 1'b0;
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_idx       <= '0;
                    r_out       <= w_fetch;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_hs) begin
                        if (r_idx == r_len) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_ACC;
                        end else begin
                            r_idx <= w_nidx;
                            r_out <= w_fetch;
                        end
                    end
                end
                default: r_state <= ST_ACC;
            endcase
            // A saturating write on the drain_start edge still flags.
            if (w_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Scoreboard bench for pe_psum_accumulator: array reference model,
// queue of expected drain words, separate output monitor.

module tb_pe_psum_accumulator;

    localparam int P  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_prod_valid;
    logic          o_prod_ready;
    logic [P-1:0]  i_prod;
    logic [AW-1:0] i_prod_addr;
    logic          i_prod_first;
    logic          o_mul_gate;
    logic          i_drain_start;
    logic [AW-1:0] i_drain_len;
    logic          i_drain_clear;
    logic          o_psum_out_valid;
    logic          i_psum_out_ready;
    logic [P-1:0]  o_psum_out;
    logic          o_drain_done;
    logic          o_ovf;

    pe_psum_accumulator #(.PSUM_SIZE(P), .DEPTH(D), .ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_prod_valid(i_prod_valid), .o_prod_ready(o_prod_ready),
        .i_prod(i_prod), .i_prod_addr(i_prod_addr),
        .i_prod_first(i_prod_first), .o_mul_gate(o_mul_gate),
        .i_drain_start(i_drain_start), .i_drain_len(i_drain_len),
        .i_drain_clear(i_drain_clear),
        .o_psum_out_valid(o_psum_out_valid),
        .i_psum_out_ready(i_psum_out_ready),
        .o_psum_out(o_psum_out), .o_drain_done(o_drain_done),
        .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int hs_edge = -1;

    logic signed [P-1:0] m [D];
    bit m_ovf;
    logic [P-1:0] exp_q[$];

    always @(posedge i_clk) cyc++;

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic model_prod(input int a, input logic [P-1:0] v, input bit first);
        longint s;
        if (first) begin
            m[a] = v;
        end else begin
            s = longint'(m[a]) + longint'($signed(v));
            if (s > 64'sd2147483647) begin
                m[a] = 32'h7FFF_FFFF;
                m_ovf = 1'b1;
            end else if (s < -64'sd2147483648) begin
                m[a] = 32'h8000_0000;
                m_ovf = 1'b1;
            end else begin
                m[a] = s[31:0];
            end
        end
    endtask

    // Output monitor: pops one expected word per handshake, checks holds.
    logic         p_v = 1'b0;
    logic         p_r = 1'b0;
    logic [P-1:0] p_d = '0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            p_v = 1'b0;
        end else begin
            if (p_v && !p_r) begin
                cmp("stall_valid", o_psum_out_valid, 1);
                cmp("stall_data", o_psum_out, p_d);
            end
            if (o_psum_out_valid && i_psum_out_ready) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_word", o_psum_out_valid, 0);
                end else begin
                    cmp("psum_out", o_psum_out, exp_q.pop_front());
                end
                hs_edge = cyc + 1;
            end
            p_v = o_psum_out_valid;
            p_r = i_psum_out_ready;
            p_d = o_psum_out;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input int a, input logic [P-1:0] v, input bit first);
        cmp("prod_ready_acc", o_prod_ready, 1);
        i_prod_valid = 1'b1;
        i_prod       = v;
        i_prod_addr  = a[AW-1:0];
        i_prod_first = first;
        tick();
        i_prod_valid = 1'b0;
        model_prod(a, v, first);
    endtask

    // rmode: 0 ready=1, 1 pattern per DRAIN cycle, 2 random
    task automatic drain(input int len, input bit clr, input int rmode,
                         input logic [15:0] pat, input int plen,
                         input bit wp, input int pa, input logic [P-1:0] pv,
                         input bit pf, input bit junk);
        int cnt;
        i_drain_start = 1'b1;
        i_drain_len   = len[AW-1:0];
        i_drain_clear = clr;
        if (wp) begin
            i_prod_valid = 1'b1;
            i_prod       = pv;
            i_prod_addr  = pa[AW-1:0];
            i_prod_first = pf;
        end
        m_ovf = 1'b0;
        if (wp) model_prod(pa, pv, pf);
        for (int i = 0; i <= len; i++) begin
            exp_q.push_back(m[i]);
            if (clr) m[i] = '0;
        end
        tick();
        i_drain_start = 1'b0;
        i_prod_valid  = 1'b0;
        cnt = 0;
        while (!o_drain_done && cnt < 300) begin
            cmp("gate_busy", {o_prod_ready, o_mul_gate}, 2'b01);
            if (rmode == 0 || cnt == 0) i_psum_out_ready = 1'b1;
            else if (rmode == 1) i_psum_out_ready = (cnt - 1 < plen) ? pat[cnt-1] : 1'b1;
            else i_psum_out_ready = 1'($urandom);
            if (junk) begin
                i_prod_valid = 1'($urandom);
                i_prod       = $urandom;
                i_prod_addr  = AW'($urandom);
                i_prod_first = 1'($urandom);
            end
            tick();
            cnt++;
        end
        i_prod_valid     = 1'b0;
        i_psum_out_ready = 1'b1;
        cmp("drain_timeout", cnt < 300, 1);
        cmp("done_timing", cyc, hs_edge);
        cmp("words_left", exp_q.size(), 0);
        cmp("gate_idle", {o_prod_ready, o_mul_gate}, 2'b10);
        tick();
        cmp("done_pulse", o_drain_done, 0);
    endtask

    task automatic check_reset_outputs();
        cmp("rst_prod_ready", o_prod_ready, 1);
        cmp("rst_mul_gate", o_mul_gate, 0);
        cmp("rst_out_valid", o_psum_out_valid, 0);
        cmp("rst_psum_out", o_psum_out, 0);
        cmp("rst_drain_done", o_drain_done, 0);
        cmp("rst_ovf", o_ovf, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_prod_valid = 1'b0;
        i_prod = '0;
        i_prod_addr = '0;
        i_prod_first = 1'b0;
        i_drain_start = 1'b0;
        i_drain_len = '0;
        i_drain_clear = 1'b0;
        i_psum_out_ready = 1'b1;
        for (int i = 0; i < D; i++) m[i] = '0;
        m_ovf = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        check_reset_outputs();

        // back-to-back accumulation into one entry
        send(2, 32'd5, 1);
        send(2, -32'sd3, 0);
        send(2, 32'd7, 0);
        drain(2, 0, 0, '0, 0, 0, 0, '0, 0, 0);
        cmp("ovf_after_plain", o_ovf, 0);

        // positive and negative saturation
        send(0, 32'h7FFF_FFF0, 1);
        send(0, 32'h20, 0);
        tick();
        cmp("ovf_pos_sat", o_ovf, m_ovf);
        send(1, 32'h8000_0005, 1);
        send(1, -32'sd10, 0);
        tick();
        cmp("ovf_neg_sat", o_ovf, m_ovf);
        drain(1, 0, 0, '0, 0, 0, 0, '0, 0, 0);
        cmp("ovf_cleared", o_ovf, 0);

        // backpressure with a fixed ready pattern
        for (int i = 0; i < 4; i++) send(i, i + 1, 1);
        drain(3, 0, 1, 16'b1011001, 7, 0, 0, '0, 0, 0);

        // drain with clear
        send(0, 32'd8, 1);
        send(1, 32'd9, 1);
        drain(1, 1, 0, '0, 0, 0, 0, '0, 0, 0);
        drain(1, 0, 0, '0, 0, 0, 0, '0, 0, 0);
        send(0, 32'd8, 1);
        send(1, 32'd9, 1);
        drain(1, 0, 0, '0, 0, 0, 0, '0, 0, 0);
        drain(1, 0, 0, '0, 0, 0, 0, '0, 0, 0);

        // product accepted together with drain_start
        send(3, 32'd10, 1);
        drain(3, 0, 0, '0, 0, 1, 3, 32'd6, 0, 1);

        // reset in the middle of a drain
        for (int i = 0; i < 8; i++) send(i, 100 + i, 1);
        i_drain_start = 1'b1;
        i_drain_len   = 4'd7;
        i_drain_clear = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(m[i]);
        tick();
        i_drain_start = 1'b0;
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < D; i++) m[i] = '0;
        m_ovf = 1'b0;
        check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("no_done_after_rst", o_drain_done, 0);
        end
        drain(7, 0, 0, '0, 0, 0, 0, '0, 0, 0);

        // randomized traffic
        for (int r = 0; r < 8; r++) begin
            int n;
            int len;
            n = $urandom_range(10, 30);
            for (int k = 0; k < n; k++) begin
                logic [P-1:0] v;
                if ($urandom_range(0, 2) == 0) v = $urandom;
                else v = 32'($urandom_range(0, 200)) - 32'd100;
                send($urandom_range(0, D - 1), v, $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) tick();
            end
            if (r == 0) len = 0;
            else if (r == 1) len = D - 1;
            else len = $urandom_range(0, D - 1);
            drain(len, 1'($urandom), 2, '0, 0,
                  1'($urandom), $urandom_range(0, D - 1),
                  32'($urandom_range(0, 50)), 1'($urandom), 1);
        end
        drain(D - 1, 0, 2, '0, 0, 0, 0, '0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
